// File: rtl/sgd_weight_update.sv
// sgd_weight_update
// In-place SGD step over the dense weight memory: w <= sat(w - (grad >>> LR_SHIFT)),
// DATA_N signed N_LEN-bit lanes per word, one word per clock.
// Optional build macro SGD_GRAD_CLEAR_EN: zero each gradient word in the same
// cycle its weight is written back, so the next accumulation pass starts clean.
//
// state | meaning
// IDLE  | waiting for run
// READ  | issuing read addresses 0..WORDS-1, one per cycle
// DRAIN | two cycles for the last reads to reach the write port
// DONE  | valid high until run falls

`ifndef DATA_N
`define DATA_N 4
`endif
`ifndef N_LEN
`define N_LEN 16
`endif

module sgd_weight_update #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORDS      = 800,
  parameter int LR_SHIFT   = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  output logic                          valid,
  output logic [ADDR_WIDTH-1:0]         raddr,
  input  logic [`DATA_N*`N_LEN-1:0]     rdata_w,
  input  logic [`DATA_N*`N_LEN-1:0]     rdata_grad,
  output logic                          we_w,
  output logic [ADDR_WIDTH-1:0]         waddr_w,
  output logic [`DATA_N*`N_LEN-1:0]     wdata_w,
  output logic                          we_grad,
  output logic [ADDR_WIDTH-1:0]         waddr_grad,
  output logic [`DATA_N*`N_LEN-1:0]     wdata_grad
);

  localparam int LANES = `DATA_N;
  localparam int NL    = `N_LEN;
  localparam int DW    = LANES * NL;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    drain_q;
  logic                    rd_pend_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [DW-1:0]           upd_word;
  logic                    keep;

  // One lane: arithmetic-shift the gradient, subtract in NL+1 bits, clamp.
  function automatic logic [NL-1:0] lane_update(input logic [NL-1:0] w,
                                                input logic [NL-1:0] g);
    logic signed [NL-1:0] delta;
    logic signed [NL:0]   diff;
    delta = $signed(g) >>> LR_SHIFT;
    diff  = {w[NL-1], w} - {delta[NL-1], delta};
    if (diff[NL] != diff[NL-1])
      lane_update = diff[NL] ? {1'b1, {(NL-1){1'b0}}} : {1'b0, {(NL-1){1'b1}}};
    else
      lane_update = diff[NL-1:0];
  endfunction

  // Next-state decode and the valid flag.
  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    case (state_q)
      IDLE:  if (run) state_d = READ;
      READ: begin
        if (!run)                    state_d = IDLE;
        else if (raddr == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        if (!run)         state_d = IDLE;
        else if (!drain_q) state_d = DONE;
      end
      DONE: begin
        valid = 1'b1;
        if (!run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Any transition into IDLE discards whatever is still in flight.
  assign keep = (state_d != IDLE);

  // Per-lane update of the word returned by the memories this cycle.
  always_comb begin
    upd_word = '0;
    for (int i = 0; i < LANES; i++)
      upd_word[i*NL +: NL] = lane_update(rdata_w[i*NL +: NL], rdata_grad[i*NL +: NL]);
  end

  // State register, read address counter and the two-stage write pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      raddr     <= '0;
      drain_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      we_w      <= 1'b0;
      waddr_w   <= '0;
      wdata_w   <= '0;
    end else begin
      state_q   <= state_d;
      raddr     <= (state_q == READ && state_d == READ) ? raddr + 1'b1 : '0;
      drain_q   <= (state_q == READ);
      rd_pend_q <= (state_q == READ) && keep;
      rd_addr_q <= raddr;
      we_w      <= rd_pend_q && keep;
      if (rd_pend_q) begin
        waddr_w <= rd_addr_q;
        wdata_w <= upd_word;
      end
    end
  end

`ifdef SGD_GRAD_CLEAR_EN
  // Gradient clear write shadows the weight write cycle for cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_grad    <= 1'b0;
      waddr_grad <= '0;
    end else begin
      we_grad <= rd_pend_q && keep;
      if (rd_pend_q) waddr_grad <= rd_addr_q;
    end
  end
`else
  assign we_grad    = 1'b0;
  assign waddr_grad = '0;
`endif

  assign wdata_grad = '0;

endmodule

// File: tb/tb_sgd_weight_update.sv
// Bench for sgd_weight_update: memory model, timeline model with a per-cycle
// compare process, and literal expectations for the directed vectors.

`ifndef DATA_N
`define DATA_N 4
`endif
`ifndef N_LEN
`define N_LEN 16
`endif

module tb_sgd_weight_update;
  localparam int AW    = 4;
  localparam int WORDS = 8;
  localparam int LR    = 7;
  localparam int NL    = `N_LEN;
  localparam int LANES = `DATA_N;
  localparam int DW    = NL * LANES;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic valid;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata_w, rdata_grad;
  logic we_w;
  logic [AW-1:0] waddr_w;
  logic [DW-1:0] wdata_w;
  logic we_grad;
  logic [AW-1:0] waddr_grad;
  logic [DW-1:0] wdata_grad;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  logic cmp_en = 1'b0;

  sgd_weight_update #(.ADDR_WIDTH(AW), .WORDS(WORDS), .LR_SHIFT(LR)) u_dut (
    .clk(clk), .rst(rst), .run(run), .valid(valid), .raddr(raddr),
    .rdata_w(rdata_w), .rdata_grad(rdata_grad),
    .we_w(we_w), .waddr_w(waddr_w), .wdata_w(wdata_w),
    .we_grad(we_grad), .waddr_grad(waddr_grad), .wdata_grad(wdata_grad)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memories: 1-cycle registered read, writes at the clock edge.
  logic [DW-1:0] wmem   [DEPTH];
  logic [DW-1:0] gmem   [DEPTH];
  logic [DW-1:0] init_w [DEPTH];
  logic [DW-1:0] init_g [DEPTH];
  logic load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) begin
        wmem[i] <= init_w[i];
        gmem[i] <= init_g[i];
      end
    end else begin
      if (we_w)    wmem[waddr_w]    <= wdata_w;
      if (we_grad) gmem[waddr_grad] <= wdata_grad;
    end
    rdata_w    <= wmem[raddr];
    rdata_grad <= gmem[raddr];
  end

  // Reference SGD step using integer floor division and clamping.
  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w, input logic [DW-1:0] g);
    logic [DW-1:0] r;
    int wi, gi, d, n, p;
    r = '0;
    p = 1 << LR;
    for (int i = 0; i < LANES; i++) begin
      wi = int'($signed(w[i*NL +: NL]));
      gi = int'($signed(g[i*NL +: NL]));
      if (gi >= 0) d = gi / p;
      else         d = -((-gi + p - 1) / p);
      n = wi - d;
      if (n > (1 << (NL-1)) - 1) n = (1 << (NL-1)) - 1;
      if (n < -(1 << (NL-1)))    n = -(1 << (NL-1));
      r[i*NL +: NL] = n[NL-1:0];
    end
    return r;
  endfunction

  // Timeline model: m_t counts cycles since the first read address went out.
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_t    = 0;
  logic [DW-1:0] snap_w [DEPTH];
  logic [DW-1:0] snap_g [DEPTH];

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_t = 0;
    end else if (m_busy) begin
      if (!run) m_busy = 1'b0;
      else begin
        m_t++;
        if (m_t == WORDS + 2) begin m_busy = 1'b0; m_done = 1'b1; end
      end
    end else if (m_done) begin
      if (!run) m_done = 1'b0;
    end else if (run) begin
      m_busy = 1'b1; m_t = 0;
      for (int i = 0; i < DEPTH; i++) begin
        snap_w[i] = wmem[i];
        snap_g[i] = gmem[i];
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin : cmp
    logic exp_we;
    int a;
    if (cmp_en) begin
      exp_we = m_busy && (m_t >= 2) && (m_t <= WORDS + 1);
      a = m_t - 2;
      check("valid", DW'(valid), DW'(m_done));
      check("we_w", DW'(we_w), DW'(exp_we));
      if (exp_we) begin
        check("waddr_w", DW'(waddr_w), DW'(a));
        check("wdata_w", wdata_w, model_word(snap_w[a], snap_g[a]));
      end
      if (m_busy && m_t < WORDS) check("raddr", DW'(raddr), DW'(m_t));
`ifdef SGD_GRAD_CLEAR_EN
      check("we_grad", DW'(we_grad), DW'(exp_we));
      if (exp_we) check("waddr_grad", DW'(waddr_grad), DW'(a));
`else
      check("we_grad", DW'(we_grad), '0);
      check("waddr_grad", DW'(waddr_grad), '0);
`endif
      check("wdata_grad", wdata_grad, '0);
    end
  end

  task automatic load_mem();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    run = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid) begin lat = cyc - start_cyc; break; end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, nw, extra;
    logic [15:0] v;
    logic [DW-1:0] exp_w [WORDS];
    logic [DW-1:0] vw [WORDS];
    logic [DW-1:0] vg [WORDS];

    for (int i = 0; i < DEPTH; i++) begin init_w[i] = '0; init_g[i] = '0; end
    repeat (3) @(negedge clk);
    load_mem();
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_valid", DW'(valid), '0);
    check("rst_raddr", DW'(raddr), '0);
    check("rst_we_w", DW'(we_w), '0);
    check("rst_waddr_w", DW'(waddr_w), '0);
    check("rst_wdata_w", wdata_w, '0);
    check("rst_we_grad", DW'(we_grad), '0);
    check("rst_waddr_grad", DW'(waddr_grad), '0);

    // Basic step and handshake hold.
    for (int i = 0; i < DEPTH; i++) begin
      init_w[i] = {LANES{16'h0100}};
      init_g[i] = {LANES{16'h0080}};
    end
    load_mem();
    start_run();
    wait_valid(lat);
    check("t1_latency", DW'(lat), DW'(11));
    for (int i = 0; i < WORDS; i++) begin
      check("t1_wmem", wmem[i], 64'h00FF_00FF_00FF_00FF);
`ifdef SGD_GRAD_CLEAR_EN
      check("t1_gmem_cleared", gmem[i], '0);
`else
      check("t1_gmem_kept", gmem[i], 64'h0080_0080_0080_0080);
`endif
    end
    extra = 0;
    repeat (10) begin @(negedge clk); if (we_w) extra++; end
    check("t5_no_rerun", DW'(extra), '0);
    check("t5_valid_held", DW'(valid), DW'(1));
    run = 1'b0;
    @(negedge clk);
    check("t5_valid_fall", DW'(valid), '0);

    // Rounding and saturation vectors.
    vw[0] = 64'h0000_0000_0000_0000; vg[0] = 64'hFFFF_FFFF_FFFF_FFFF; exp_w[0] = 64'h0001_0001_0001_0001;
    vw[1] = 64'h7FFF_7FFF_7FFF_7FFF; vg[1] = 64'h8000_8000_8000_8000; exp_w[1] = 64'h7FFF_7FFF_7FFF_7FFF;
    vw[2] = 64'h8000_8000_8000_8000; vg[2] = 64'h7FFF_7FFF_7FFF_7FFF; exp_w[2] = 64'h8000_8000_8000_8000;
    vw[3] = 64'h0000_1234_8000_7FFF; vg[3] = 64'hFF80_0100_7FFF_8000; exp_w[3] = 64'h0001_1232_8000_7FFF;
    vw[4] = 64'h0005_0005_0005_0005; vg[4] = 64'h007F_007F_007F_007F; exp_w[4] = 64'h0005_0005_0005_0005;
    vw[5] = 64'hFFFE_FFFE_FFFE_FFFE; vg[5] = 64'hFF00_FF00_FF00_FF00; exp_w[5] = 64'h0000_0000_0000_0000;
    vw[6] = 64'h7F00_7F00_7F00_7F00; vg[6] = 64'h8000_8000_8000_8000; exp_w[6] = 64'h7FFF_7FFF_7FFF_7FFF;
    vw[7] = 64'h8100_8100_8100_8100; vg[7] = 64'h7FFF_7FFF_7FFF_7FFF; exp_w[7] = 64'h8001_8001_8001_8001;
    for (int i = 0; i < WORDS; i++) begin init_w[i] = vw[i]; init_g[i] = vg[i]; end
    load_mem();
    start_run();
    wait_valid(lat);
    check("t23_latency", DW'(lat), DW'(11));
    for (int i = 0; i < WORDS; i++) check("t23_wmem", wmem[i], exp_w[i]);
    run = 1'b0;
    @(negedge clk);

    // Abort after two writes, then a clean re-run.
    for (int i = 0; i < WORDS; i++) begin
      v = 16'h0200 + 16'(i);
      init_w[i] = {LANES{v}};
      init_g[i] = {LANES{16'h0100}};
    end
    load_mem();
    start_run();
    nw = 0;
    for (int i = 0; i < 30 && nw < 2; i++) begin
      @(negedge clk);
      if (we_w) nw++;
    end
    check("t4_two_writes_seen", DW'(nw), DW'(2));
    run = 1'b0;
    extra = 0;
    repeat (4) begin @(negedge clk); if (we_w || valid) extra++; end
    check("t4_quiet_after_abort", DW'(extra), '0);
    check("t4_w0", wmem[0], 64'h01FE_01FE_01FE_01FE);
    check("t4_w1", wmem[1], 64'h01FF_01FF_01FF_01FF);
    check("t4_w2", wmem[2], 64'h0202_0202_0202_0202);
    check("t4_w7", wmem[7], 64'h0207_0207_0207_0207);
    start_run();
    wait_valid(lat);
    check("t4_rerun_latency", DW'(lat), DW'(11));
    check("t4_rerun_w2", wmem[2], 64'h0200_0200_0200_0200);
    check("t4_rerun_w7", wmem[7], 64'h0205_0205_0205_0205);
    run = 1'b0;
    @(negedge clk);

    // Reset in the middle of an update.
    start_run();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check("rstmid_we_w", DW'(we_w), '0);
    check("rstmid_raddr", DW'(raddr), '0);
    check("rstmid_waddr_w", DW'(waddr_w), '0);
    check("rstmid_wdata_w", wdata_w, '0);
    check("rstmid_valid", DW'(valid), '0);
    check("rstmid_we_grad", DW'(we_grad), '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
